// File: rtl/phys_reg_freelist.sv
// phys_reg_freelist: circular free list of physical registers with checkpoint recovery
//
// Hands one free physical register per cycle to rename, accepts one released
// register per cycle from commit, and on mispredict rewinds the head to a
// checkpointed index so every register allocated on the squashed path is free again.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   alloc_req       rename wants a register this cycle
//   alloc_gnt       a register is granted (combinational)
//   alloc_preg      granted register, valid with alloc_gnt
//   ckpt_ptr        current head index, saved by rename in the ROB checkpoint
//   free_valid      commit releases free_preg
//   free_preg       released register (p0 is never recycled)
//   recover_valid   mispredict recovery, head <- recover_ptr
//   recover_ptr     checkpointed head index, 0..DEPTH-1
//   free_count      number of free entries, 0..DEPTH
//   empty           free_count == 0
//   overflow        sticky: a free was dropped because the list was full
//
// Optional feature: define FREELIST_BYPASS_EN to let a same-cycle free satisfy an
// allocation when the list is empty.
module phys_reg_freelist #(
    parameter int NUM_PHYS_REGS = 128,
    parameter int NUM_ARCH_REGS = 32,
    parameter int PHYS_REG_BITS = $clog2(NUM_PHYS_REGS),
    parameter int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_req,
    output logic                     alloc_gnt,
    output logic [PHYS_REG_BITS-1:0] alloc_preg,
    output logic [PHYS_REG_BITS-1:0] ckpt_ptr,
    input  logic                     free_valid,
    input  logic [PHYS_REG_BITS-1:0] free_preg,
    input  logic                     recover_valid,
    input  logic [PHYS_REG_BITS-1:0] recover_ptr,
    output logic [PHYS_REG_BITS-1:0] free_count,
    output logic                     empty,
    output logic                     overflow
);
    localparam int W = PHYS_REG_BITS + 1;
    localparam logic [W-1:0]             DEPTH_X = W'(DEPTH);
    localparam logic [PHYS_REG_BITS-1:0] DEPTH_N = PHYS_REG_BITS'(DEPTH);

    logic [PHYS_REG_BITS-1:0] storage_q [DEPTH];
    logic [PHYS_REG_BITS-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic                     overflow_q, overflow_d;
    logic                     full, free_ok, byp, push, pop;
    logic [PHYS_REG_BITS-1:0] head_inc, tail_inc, rec_dist;

    // Index arithmetic is done one bit wider and then folded back into 0..DEPTH-1.
    function automatic logic [PHYS_REG_BITS-1:0] wrap(input logic [W-1:0] x);
        return (x >= DEPTH_X) ? PHYS_REG_BITS'(x - DEPTH_X) : x[PHYS_REG_BITS-1:0];
    endfunction

    assign full    = (count_q == DEPTH_N);
    assign free_ok = free_valid && (free_preg != '0) && !full;

`ifdef FREELIST_BYPASS_EN
    // Empty list: the register being freed goes straight to rename without touching storage.
    assign byp = alloc_req && (count_q == '0) && free_ok && !recover_valid;
`else
    assign byp = 1'b0;
`endif

    assign alloc_gnt  = alloc_req && !recover_valid && ((count_q != '0) || byp);
    assign alloc_preg = byp ? free_preg : storage_q[head_q];
    assign push       = free_ok && !byp;
    assign pop        = alloc_gnt && !byp;

    assign head_inc = wrap({1'b0, head_q} + W'(1));
    assign tail_inc = wrap({1'b0, tail_q} + W'(1));
    // Number of slots allocated since the checkpoint; they become free again on recovery.
    assign rec_dist = wrap({1'b0, head_q} + DEPTH_X - {1'b0, recover_ptr});

    always_comb begin
        tail_d     = push ? tail_inc : tail_q;
        overflow_d = overflow_q || (free_valid && (free_preg != '0) && full);
        head_d     = recover_valid ? recover_ptr : (pop ? head_inc : head_q);
        count_d    = recover_valid
                   ? PHYS_REG_BITS'({1'b0, count_q} + {1'b0, rec_dist} + W'(push))
                   : PHYS_REG_BITS'(count_q + PHYS_REG_BITS'(push) - PHYS_REG_BITS'(pop));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= DEPTH_N;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                storage_q[i] <= PHYS_REG_BITS'(NUM_ARCH_REGS + i);
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push)
                storage_q[tail_q] <= free_preg;
        end
    end

    assign ckpt_ptr   = head_q;
    assign free_count = count_q;
    assign empty      = (count_q == '0);
    assign overflow   = overflow_q;
endmodule

// File: tb/tb_phys_reg_freelist.sv
// tb_phys_reg_freelist: directed and randomized checks of phys_reg_freelist against a ring-buffer model
module tb_phys_reg_freelist;
    localparam int D = 96;
`ifdef FREELIST_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_req, alloc_gnt, free_valid, recover_valid, empty, overflow;
    logic [6:0] alloc_preg, ckpt_ptr, free_preg, recover_ptr, free_count;

    int n_cmp = 0, n_err = 0;
    int m_mem [D];
    int m_head, m_tail, m_cnt;
    bit m_ovf;
    int g_gnt, g_preg;

    phys_reg_freelist dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_preg(alloc_preg),
        .ckpt_ptr(ckpt_ptr),
        .free_valid(free_valid), .free_preg(free_preg),
        .recover_valid(recover_valid), .recover_ptr(recover_ptr),
        .free_count(free_count), .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < D; i++) m_mem[i] = 32 + i;
        m_head = 0;
        m_tail = 0;
        m_cnt  = D;
        m_ovf  = 0;
    endfunction

    // One clock cycle: entered at a falling edge, returns at the next falling edge.
    task automatic cyc(input bit req, input bit fv, input int fp, input bit rv, input int rp);
        bit fok, byp, gnt, push, pop;
        alloc_req = req; free_valid = fv; free_preg = 7'(fp);
        recover_valid = rv; recover_ptr = 7'(rp);
        fok = fv && fp != 0 && m_cnt < D;
        byp = BYP && req && m_cnt == 0 && fok && !rv;
        gnt = req && !rv && (m_cnt > 0 || byp);
        #1;
        g_gnt  = int'(alloc_gnt);
        g_preg = int'(alloc_preg);
        check("gnt", g_gnt, int'(gnt));
        if (gnt) check("preg", g_preg, byp ? fp : m_mem[m_head]);
        @(posedge clk);
        push = fok && !byp;
        pop  = gnt && !byp;
        if (fv && fp != 0 && m_cnt == D) m_ovf = 1;
        if (push) begin
            m_mem[m_tail] = fp;
            m_tail = (m_tail + 1) % D;
        end
        if (rv) begin
            m_cnt += (m_head - rp + D) % D + int'(push);
            m_head = rp;
        end else begin
            if (pop) m_head = (m_head + 1) % D;
            m_cnt += int'(push) - int'(pop);
        end
        @(negedge clk);
        check("count", int'(free_count), m_cnt);
        check("empty", int'(empty), int'(m_cnt == 0));
        check("ckpt", int'(ckpt_ptr), m_head);
        check("ovf", int'(overflow), int'(m_ovf));
        if (rv) check("rcv_le_depth", int'(int'(free_count) <= D), 1);
    endtask

    task automatic idle_inputs();
        alloc_req = 0; free_valid = 0; free_preg = '0; recover_valid = 0; recover_ptr = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        alloc_req = 1;
        #1;
        check("rst_gnt", int'(alloc_gnt), 1);
        check("rst_preg", int'(alloc_preg), 32);
        check("rst_ckpt", int'(ckpt_ptr), 0);
        check("rst_count", int'(free_count), 96);
        check("rst_empty", int'(empty), 0);
        check("rst_ovf", int'(overflow), 0);
        alloc_req = 0;
    endtask

    task automatic allocs(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;

        // Drain the whole list in order, then free and reallocate across the wrap.
        do_reset();
        for (int i = 0; i < D; i++) begin
            cyc(1, 0, 0, 0, 0);
            check("seq_preg", g_preg, 32 + i);
        end
        check("drain_empty", int'(empty), 1);
        check("drain_count", int'(free_count), 0);
        check("drain_head_wrap", int'(ckpt_ptr), 0);
        cyc(1, 0, 0, 0, 0);
        check("empty_no_gnt", g_gnt, 0);
        cyc(0, 1, 40, 0, 0);
        cyc(0, 1, 41, 0, 0);
        check("two_free_cnt", int'(free_count), 2);
        cyc(1, 0, 0, 0, 0);
        check("realloc_p40", g_preg, 40);
        check("realloc_cnt1", int'(free_count), 1);
        cyc(1, 0, 0, 0, 0);
        check("realloc_p41", g_preg, 41);
        check("realloc_cnt0", int'(free_count), 0);

        // Alloc and free together on an empty list.
        cyc(1, 1, 9, 0, 0);
`ifdef FREELIST_BYPASS_EN
        check("byp_gnt", g_gnt, 1);
        check("byp_preg", g_preg, 9);
        check("byp_cnt", int'(free_count), 0);
`else
        check("nobyp_gnt", g_gnt, 0);
        check("nobyp_cnt", int'(free_count), 1);
        cyc(1, 0, 0, 0, 0);
        check("nobyp_next_gnt", g_gnt, 1);
        check("nobyp_next_preg", g_preg, 9);
`endif

        // Checkpoint recovery.
        do_reset();
        allocs(5);
        check("ckpt5", int'(ckpt_ptr), 5);
        allocs(10);
        check("cnt81", int'(free_count), 81);
        cyc(0, 0, 0, 1, 5);
        check("rcv_cnt91", int'(free_count), 91);
        cyc(1, 0, 0, 0, 0);
        check("rcv_preg37", g_preg, 37);
        cyc(1, 0, 0, 1, m_head);
        check("rcv_alloc_gnt0", g_gnt, 0);

        // Alloc + free at count 50, then walk to the slot that took p3.
        do_reset();
        allocs(46);
        cyc(1, 1, 3, 0, 0);
        check("af_cnt50", int'(free_count), 50);
        allocs(49);
        cyc(1, 0, 0, 0, 0);
        check("af_p3_reused", g_preg, 3);

        // Overflow when full; p0 ignored.
        do_reset();
        cyc(0, 1, 7, 0, 0);
        check("ovf_set", int'(overflow), 1);
        check("ovf_cnt96", int'(free_count), 96);
        do_reset();
        allocs(86);
        cyc(0, 1, 0, 0, 0);
        check("p0_cnt10", int'(free_count), 10);
        check("p0_no_ovf", int'(overflow), 0);

        // Randomized traffic with legal recoveries and a mid-run asynchronous reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int bias, fp, k, lim;
            bit req, fv, rv, fok;
            bias = (c / 150) % 3;
            req  = $urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 3 : 5));
            fv   = $urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 8 : 5));
            fp   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 127));
            rv   = $urandom_range(0, 19) == 0;
            fok  = fv && fp != 0 && m_cnt < D;
            lim  = D - m_cnt - int'(fok);
            k    = (lim > 0) ? int'($urandom_range(0, lim)) : 0;
            cyc(req, fv, fp, rv, (m_head - k + D) % D);
            if (c == 1500) begin
                #2;
                rst_n = 0;
                #1;
                check("async_rst_cnt", int'(free_count), 96);
                check("async_rst_ckpt", int'(ckpt_ptr), 0);
                check("async_rst_ovf", int'(overflow), 0);
                model_reset();
                idle_inputs();
                @(negedge clk);
                rst_n = 1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
